// File: rtl/async_fifo_rd_packer.sv
// Read-side packer behind async_fifo: pops first-word-fall-through words and packs
// PACK of them into one wide word on a valid/ready stream, with flush of partial words.
module async_fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       rempty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rinc,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [$clog2(PACK):0]      m_count,
  output logic                       m_last,
  output logic [CNT_WIDTH-1:0]       words_popped,
  output logic                       busy
);

  localparam int NW = $clog2(PACK);
  localparam int CW = NW + 1;
  localparam int LW = DATA_WIDTH * PACK;
  localparam logic [NW-1:0] LAST_LANE = NW'(PACK - 1);

  // Handshake: a word transfers on every rclk edge where m_valid & m_ready are both 1;
  // m_data/m_count/m_last stay stable while m_valid=1 and m_ready=0.

  logic [DATA_WIDTH-1:0] acc [PACK-1];
  logic [NW-1:0]         n;
  logic                  flush_pend;
  logic                  out_free;
  logic                  pop;
  logic                  flush_fire;
  logic [LW-1:0]         full_word;
  logic [LW-1:0]         partial_word;

  assign out_free   = ~m_valid | m_ready;
  // Gating uses the registered flush_pend, so a pop in the flush-pulse cycle still runs.
  assign pop        = ~rrst & ~rempty & ~flush_pend & ((n < LAST_LANE) | out_free);
  assign rinc       = pop;
  assign flush_fire = flush_pend & out_free;
  assign busy       = (n != '0) | m_valid | flush_pend;

  always_comb begin
    full_word    = '0;
    partial_word = '0;
    for (int i = 0; i < PACK - 1; i++) begin
      full_word[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
      if (i < int'(n)) begin
        partial_word[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
      end
    end
    full_word[(PACK-1)*DATA_WIDTH +: DATA_WIDTH] = rdata;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < PACK - 1; i++) begin
        acc[i] <= '0;
      end
      n            <= '0;
      flush_pend   <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_count      <= '0;
      m_last       <= 1'b0;
      words_popped <= '0;
    end else begin
      // A load below overrides this clear, keeping m_valid high across a handoff.
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (pop) begin
        words_popped <= words_popped + CNT_WIDTH'(1);
        if (n == LAST_LANE) begin
          m_data  <= full_word;
          m_count <= CW'(PACK);
          m_last  <= 1'b0;
          m_valid <= 1'b1;
          n       <= '0;
        end else begin
          acc[n] <= rdata;
          n      <= n + NW'(1);
        end
      end

      if (flush_fire) begin
        flush_pend <= 1'b0;
        if (n != '0) begin
          m_data  <= partial_word;
          m_count <= {1'b0, n};
          m_last  <= 1'b1;
          m_valid <= 1'b1;
        end
        n <= '0;
      end else if (flush && !flush_pend) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule
